alu_share_ctrl: RTL

//  Shares one combinational ALU (operand1/operand2/alu_op -> result/zero_flag)

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/alu_share_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU controller and its users.
package alu_pkg;

    // ALU opcode encoding understood by the shared ALU
    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;

    // Controller sequencing: accept a request, let the ALU settle, hold the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

endpackage : alu_pkg

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index found by searching
// upward from ptr and wrapping at N. Purely combinational.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   idx;
    logic found;

    // Rotating priority search starting at ptr; the first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// arbitration, registers the ALU outputs and returns them tagged with the
// requester index over a single backpressured response channel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A requester holds req_valid and its operands stable until it
// sees its req_ready bit; req_ready never depends on rsp_ready. The response
// side holds rsp_valid/rsp_id/rsp_result/rsp_zero stable until rsp_ready.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    parameter  int OP_W    = 3,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand1,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand2,
    input  logic [NUM_REQ*OP_W-1:0]   req_alu_op,
    output logic [DATA_W-1:0]         alu_operand1,
    output logic [DATA_W-1:0]         alu_operand2,
    output logic [OP_W-1:0]           alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      busy,
    output ctrl_state_e               state_dbg
);

    ctrl_state_e         state;
    ctrl_state_e         state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                accept;
    logic [DATA_W-1:0]   sel_operand1;
    logic [DATA_W-1:0]   sel_operand2;
    logic [OP_W-1:0]     sel_alu_op;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A request is taken only from IDLE; the arbiter guarantees one winner
    assign accept = (state == IDLE) && (|req_valid);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; req_ready is held low while reset is asserted
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && rst_n) begin
            req_ready = gnt;
        end
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Route the granted requester's operation onto the capture path
    always_comb begin
        sel_operand1 = '0;
        sel_operand2 = '0;
        sel_alu_op   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_operand1 = req_operand1[i*DATA_W +: DATA_W];
                sel_operand2 = req_operand2[i*DATA_W +: DATA_W];
                sel_alu_op   = req_alu_op[i*OP_W +: OP_W];
            end
        end
    end

    // Capture the granted operation and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_op       <= '0;
            rsp_id       <= '0;
            rr_ptr       <= '0;
        end else if (accept) begin
            alu_operand1 <= sel_operand1;
            alu_operand2 <= sel_operand2;
            alu_op       <= sel_alu_op;
            rsp_id       <= gnt_idx;
            rr_ptr       <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Register the settled ALU outputs and hold them until the consumer takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule : alu_share_ctrl
